// File: rtl/wir_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wir_ctrl
//  Brief    : IEEE 1500 wrapper instruction register (WIR), wrapper bypass
//             register (WBY) and serial control decoder for the input wrapper
//             boundary register chain. Drives wse_inputs / hold_inputs,
//             selects WSO and flags misuse of the WSC strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module wir_ctrl #(
    parameter int unsigned              WIR_WIDTH   = 3,
    parameter logic [WIR_WIDTH-1:0]     CAPTURE_VAL = {{(WIR_WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                    CLK,
    input  logic                    resetn,        // synchronous, active-high
    input  logic                    WSI,
    input  logic                    SelectWIR,
    input  logic                    CaptureWR,
    input  logic                    ShiftWR,
    input  logic                    UpdateWR,
    input  logic                    WBR_SO,
    output logic                    WSO,
    output logic                    wse_inputs,
    output logic                    hold_inputs,
    output logic                    wbr_sel,
    output logic                    core_in_mode,
    output logic                    core_out_mode,
    output logic                    safe_state,
    output logic [WIR_WIDTH-1:0]    wir_q,
    output logic                    wsc_err
);

    // ------------------------------------------------------------------------
    // Opcodes and constants
    // ------------------------------------------------------------------------
    localparam logic [WIR_WIDTH-1:0] c_OP_BYPASS  = WIR_WIDTH'(0);
    localparam logic [WIR_WIDTH-1:0] c_OP_EXTEST  = WIR_WIDTH'(1);
    localparam logic [WIR_WIDTH-1:0] c_OP_INTEST  = WIR_WIDTH'(2);
    localparam logic [WIR_WIDTH-1:0] c_OP_PRELOAD = WIR_WIDTH'(3);
    localparam logic [WIR_WIDTH-1:0] c_OP_SAFE    = WIR_WIDTH'(4);
    localparam logic [3:0]           c_CNT_MAX    = 4'd15;

    // Strobe-sequence tracker states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAP   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_UPD   = 2'd3
    } wsc_state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [WIR_WIDTH-1:0]   r_stage;       // WIR shift stage
    logic [WIR_WIDTH-1:0]   r_wir_q;       // WIR update stage (active instruction)
    logic [3:0]             r_shift_cnt;   // shifts seen since last WIR capture
    logic                   r_wby;         // wrapper bypass bit
    logic                   r_err;         // sticky protocol error
    logic                   r_sel_prev;    // SelectWIR seen on the last legal cycle
    wsc_state_t             r_wir_state;
    wsc_state_t             r_dr_state;

    // ------------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------------
    logic                   w_illegal;
    logic                   w_sel_chg;
    logic                   w_upd_ok;
    logic                   w_dr_active;
    logic                   w_wbr_sel;
    logic                   w_core_in;
    logic                   w_core_out;
    logic                   w_safe;
    wsc_state_t             w_wir_base;
    wsc_state_t             w_dr_base;
    wsc_state_t             w_wir_state_nxt;
    wsc_state_t             w_dr_state_nxt;

    // More than one strobe in the same cycle is a protocol violation.
    assign w_illegal = (CaptureWR & ShiftWR) | (CaptureWR & UpdateWR) | (ShiftWR & UpdateWR);

    // A change of path restarts both sequence trackers from IDLE.
    assign w_sel_chg = (SelectWIR != r_sel_prev);

    // An update is accepted only after at least a full WIR length of shifts.
    assign w_upd_ok  = (32'(r_shift_cnt) >= WIR_WIDTH);

    // WBR cells only see capture/shift when a WBR instruction is active on
    // the data-register path and the strobes are well-formed.
    assign w_dr_active = ~w_illegal & ~SelectWIR & w_wbr_sel;

    // ------------------------------------------------------------------------
    // Strobe-sequence next state for one tracker. Capture is accepted from
    // IDLE and from UPD, since UPD falls through to IDLE anyway.
    // ------------------------------------------------------------------------
    function automatic wsc_state_t f_next(input wsc_state_t cur,
                                          input logic cap,
                                          input logic sh,
                                          input logic upd);
        wsc_state_t nxt;
        nxt = cur;
        if (upd) begin
            nxt = ST_UPD;
        end else if (sh && (cur == ST_CAP || cur == ST_SHIFT)) begin
            nxt = ST_SHIFT;
        end else if (cap && (cur == ST_IDLE || cur == ST_UPD)) begin
            nxt = ST_CAP;
        end else if (!cap && !sh && cur == ST_UPD) begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

    // Next-state logic for the WIR and DR sequence trackers.
    always_comb begin
        w_wir_base      = w_sel_chg ? ST_IDLE : r_wir_state;
        w_dr_base       = w_sel_chg ? ST_IDLE : r_dr_state;
        w_wir_state_nxt = r_wir_state;
        w_dr_state_nxt  = r_dr_state;
        if (!w_illegal) begin
            if (SelectWIR) begin
                w_wir_state_nxt = f_next(w_wir_base, CaptureWR, ShiftWR, UpdateWR);
                w_dr_state_nxt  = w_dr_base;
            end else begin
                w_wir_state_nxt = w_wir_base;
                w_dr_state_nxt  = f_next(w_dr_base, CaptureWR, ShiftWR, UpdateWR);
            end
        end
    end

    // Tracker state registers; frozen on an illegal cycle.
    always_ff @(posedge CLK) begin
        if (resetn) begin
            r_wir_state <= ST_IDLE;
            r_dr_state  <= ST_IDLE;
            r_sel_prev  <= 1'b0;
        end else if (!w_illegal) begin
            r_wir_state <= w_wir_state_nxt;
            r_dr_state  <= w_dr_state_nxt;
            r_sel_prev  <= SelectWIR;
        end
    end

    // WIR shift stage, shift counter and update stage.
    always_ff @(posedge CLK) begin
        if (resetn) begin
            r_stage     <= '0;
            r_shift_cnt <= 4'd0;
            r_wir_q     <= c_OP_BYPASS;
        end else if (!w_illegal && SelectWIR) begin
            if (CaptureWR) begin
                r_stage     <= CAPTURE_VAL;
                r_shift_cnt <= 4'd0;
            end
            if (ShiftWR) begin
                r_stage <= {WSI, r_stage[WIR_WIDTH-1:1]};
                if (r_shift_cnt != c_CNT_MAX) begin
                    r_shift_cnt <= r_shift_cnt + 4'd1;
                end
            end
            if (UpdateWR && w_upd_ok) begin
                r_wir_q <= r_stage;
            end
        end
    end

    // Wrapper bypass register on the data-register path.
    always_ff @(posedge CLK) begin
        if (resetn) begin
            r_wby <= 1'b0;
        end else if (!w_illegal && !SelectWIR) begin
            if (CaptureWR) begin
                r_wby <= 1'b0;
            end else if (ShiftWR) begin
                r_wby <= WSI;
            end
        end
    end

    // Sticky error: overlapping strobes or a short-shifted WIR update.
    always_ff @(posedge CLK) begin
        if (resetn) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end else if (SelectWIR && UpdateWR && !w_upd_ok) begin
            r_err <= 1'b1;
        end
    end

    // Instruction decode from the active instruction only; unknown codes bypass.
    always_comb begin
        w_wbr_sel  = 1'b0;
        w_core_in  = 1'b0;
        w_core_out = 1'b0;
        w_safe     = 1'b0;
        case (r_wir_q)
            c_OP_EXTEST: begin
                w_wbr_sel  = 1'b1;
                w_core_out = 1'b1;
            end
            c_OP_INTEST: begin
                w_wbr_sel = 1'b1;
                w_core_in = 1'b1;
            end
            c_OP_PRELOAD: begin
                w_wbr_sel = 1'b1;
            end
            c_OP_SAFE: begin
                w_safe = 1'b1;
            end
            default: begin
                w_wbr_sel = 1'b0;
            end
        endcase
    end

    // Serial output path selection.
    always_comb begin
        WSO = r_wby;
        if (SelectWIR) begin
            WSO = r_stage[0];
        end else if (w_wbr_sel) begin
            WSO = WBR_SO;
        end
    end

    // WBR cell controls are combinational so the cells act on the same edge.
    assign wse_inputs    = w_dr_active & ShiftWR;
    assign hold_inputs   = ~(w_dr_active & (ShiftWR | CaptureWR));

    assign wbr_sel       = w_wbr_sel;
    assign core_in_mode  = w_core_in;
    assign core_out_mode = w_core_out;
    assign safe_state    = w_safe;
    assign wir_q         = r_wir_q;
    assign wsc_err       = r_err;

endmodule
`default_nettype wire
